// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps up to MAX_OUT word requests in flight and
// queues returned words with their PC+4 for IF/ID. A branch redirect flushes the queue and discards
// any responses that are still in flight.
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] MAX_OUT_C = (CW+1)'(MAX_OUT);
  localparam logic [CW:0] DEPTH_C   = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] live;
  logic [CW-1:0] stale;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc4   [DEPTH];

  logic          issue;
  logic          drop;
  logic          push;
  logic          pop;
  logic          rsp_any;
  logic [CW:0]   inflight;
  logic [CW:0]   occupied;
  logic [31:0]   target_pc;

  always_comb begin
    inflight  = {1'b0, live} + {1'b0, stale};
    occupied  = {1'b0, count} + {1'b0, live};
    target_pc = {redirect_pc_i[31:2], 2'b00};
    // Credit rule: every live request already owns a queue slot, so a push can never overflow.
    issue     = !rst_i && !redirect_i && (inflight < MAX_OUT_C) && (occupied < DEPTH_C);
    rsp_any   = imem_rvalid_i && ((live != '0) || (stale != '0));
    drop      = imem_rvalid_i && (stale != '0);
    push      = imem_rvalid_i && (stale == '0) && (live != '0);
    instr_valid_o = (count != '0) && !redirect_i;
    pop       = instr_valid_o && instr_ready_i;
    imem_req_o  = issue;
    imem_addr_o = fetch_pc;
    instr_o     = (count != '0) ? q_instr[rd_ptr] : 32'h0;
    pc_plus4_o  = (count != '0) ? q_pc4[rd_ptr]   : 32'h0;
  end

  // Control state: PCs, in-flight accounting, queue pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      live     <= '0;
      stale    <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_i) begin
      // Everything still in flight becomes stale; a response landing now is already discarded.
      fetch_pc <= target_pc;
      resp_pc  <= target_pc;
      live     <= '0;
      stale    <= stale + live - CW'(rsp_any);
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      live  <= live + CW'(issue) - CW'(push);
      stale <= stale - CW'(drop);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage: data only, never reset; occupancy masks stale contents
  always_ff @(posedge clk_i) begin
    if (push && !redirect_i) begin
      q_instr[wr_ptr] <= imem_rdata_i;
      q_pc4[wr_ptr]   <= resp_pc + 32'd4;
    end
  end

endmodule
